// File: rtl/dmem_controller.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a read-only debug port,
// stretching each access over ACCESS_LAT cycles. A starvation guard lets a long-pending debug read win.
// state    | meaning
// IDLE     | no access in flight, arbitrating
// CPU_BUSY | CPU load/store occupying the memory
// DBG_BUSY | debug read occupying the memory
module dmem_controller #(
  parameter int ACCESS_LAT = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_MemRead,
  input  logic        cpu_MemWrite,
  input  logic [31:0] cpu_Address,
  input  logic [31:0] cpu_Writedata,
  output logic [31:0] cpu_Readdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic [31:0] dbg_Address,
  output logic [31:0] dbg_Readdata,
  output logic        dbg_ack,
  output logic        mem_MemRead,
  output logic        mem_MemWrite,
  output logic [31:0] mem_Address,
  output logic [31:0] mem_Writedata,
  input  logic [31:0] mem_Readdata
);

  localparam logic [3:0] LAT_M1 = 4'(ACCESS_LAT - 1);
  localparam logic [3:0] MAX_W  = 4'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, CPU_BUSY, DBG_BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic        dbg_ack_q, dbg_ack_d;

  logic cpu_req;
  logic dbg_live;
  logic dbg_grant;
  logic busy;
  logic cpu_final;

  assign cpu_req   = cpu_MemRead | cpu_MemWrite;
  // The ack cycle itself is not a new request; the requester drops dbg_req on seeing the ack.
  assign dbg_live  = dbg_req & ~dbg_ack_q;
  assign busy      = (state_q != IDLE) & ~reset;
  assign cpu_final = (state_q == CPU_BUSY) && (cnt_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    dbg_ack_d   = 1'b0;
    dbg_grant   = 1'b0;

    case (state_q)
      IDLE: begin
        if (dbg_live && (wcnt_q >= MAX_W)) begin
          dbg_grant = 1'b1;
        end else if (cpu_req) begin
          state_d = CPU_BUSY;
          cnt_d   = LAT_M1;
          addr_d  = cpu_Address;
          wdata_d = cpu_Writedata;
          we_d    = cpu_MemWrite;
        end else if (dbg_live) begin
          dbg_grant = 1'b1;
        end
        if (dbg_grant) begin
          state_d = DBG_BUSY;
          cnt_d   = LAT_M1;
          addr_d  = dbg_Address;
          wdata_d = 32'd0;
          we_d    = 1'b0;
        end
      end
      CPU_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          if (!we_q) cpu_rdata_d = mem_Readdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DBG_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d     = IDLE;
          dbg_rdata_d = mem_Readdata;
          dbg_ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!dbg_req || dbg_grant) begin
      wcnt_d = 4'd0;
    end else if ((state_q != DBG_BUSY) && (wcnt_q != 4'hF)) begin
      wcnt_d = wcnt_q + 4'd1;
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      wcnt_q      <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
      cpu_rdata_q <= 32'd0;
      dbg_rdata_q <= 32'd0;
      dbg_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      dbg_ack_q   <= dbg_ack_d;
    end
  end

  // Strobes come only from registered state so input changes cannot glitch them.
  assign mem_MemRead   = busy & ~((state_q == CPU_BUSY) & we_q);
  assign mem_MemWrite  = busy & cpu_final & we_q;
  assign mem_Address   = busy ? addr_q  : 32'd0;
  assign mem_Writedata = busy ? wdata_q : 32'd0;

  assign cpu_Readdata  = (~reset & cpu_final & ~we_q) ? mem_Readdata : cpu_rdata_q;
  assign cpu_stall     = cpu_req & ~reset & ~cpu_final;
  assign dbg_Readdata  = dbg_rdata_q;
  assign dbg_ack       = dbg_ack_q;

endmodule
